// File: rtl/axi_addr_router.sv
// axi_addr_router: decodes one AXI address channel (AR or AW) onto NUM_S mapped
// slaves plus a default decode-error slave. It tracks the transactions still
// awaiting a response and stalls any request that could reorder responses
// across slaves.
module axi_addr_router #(
    parameter int unsigned NUM_S   = 6,
    parameter int unsigned ADDR_W  = 32,
    parameter logic [NUM_S*ADDR_W-1:0] BASE = '0,
    parameter logic [NUM_S*ADDR_W-1:0] MASK = '0,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_S + 1),
    parameter int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_addr,
    output logic              m_ready,
    output logic [NUM_S:0]    s_valid,
    input  logic [NUM_S:0]    s_ready,
    input  logic              rsp_done,
    output logic [SEL_W-1:0]  rsp_sel,
    output logic              busy,
    output logic [CNT_W-1:0]  outstanding,
    output logic              protocol_err
);

    localparam int unsigned PORTS = NUM_S + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] target;
    logic             allowed;
    logic             accept;

    // Address decode: the lowest-numbered hitting region wins; a miss selects the default slave
    always_comb begin
        target = SEL_W'(NUM_S);
        for (int i = int'(NUM_S) - 1; i >= 0; i--) begin
            if ((m_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                target = SEL_W'(i);
            end
        end
    end

    // Request gating: only the current owner may add transactions, and only while below the depth limit
    always_comb begin
        allowed = m_valid &&
                  ((state_q == IDLE) ||
                   ((target == sel_q) && (cnt_q < CNT_W'(MAX_OUT))));
        s_valid = allowed ? (PORTS'(1) << target) : '0;
        m_ready = allowed && s_ready[target];
        accept  = m_ready;
    end

    // Next state for the tracking FSM, outstanding counter, owner and sticky error
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        err_d   = err_q;
        if (accept) begin
            sel_d = target;
        end
        if (accept && !rsp_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && rsp_done && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (rsp_done && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
        case (state_q)
            IDLE:    if (cnt_d != '0) state_d = ACTIVE;
            ACTIVE:  if (cnt_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign outstanding  = cnt_q;
    assign rsp_sel      = sel_q;
    assign busy         = (state_q == ACTIVE);
    assign protocol_err = err_q;

endmodule

// File: tb/tb_axi_addr_router.sv
// Directed bench for axi_addr_router: 3 slaves plus default, depth 2.
module tb_axi_addr_router;

    localparam int unsigned NUM_S  = 3;
    localparam int unsigned ADDR_W = 32;
    localparam logic [NUM_S*ADDR_W-1:0] BASE_V =
        {32'h2000_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NUM_S*ADDR_W-1:0] MASK_V =
        {32'hFF80_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_ready;
    logic [3:0]  s_valid;
    logic [3:0]  s_ready;
    logic        rsp_done;
    logic [1:0]  rsp_sel;
    logic        busy;
    logic [1:0]  outstanding;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    axi_addr_router #(
        .NUM_S(NUM_S), .ADDR_W(ADDR_W), .BASE(BASE_V), .MASK(MASK_V), .MAX_OUT(2)
    ) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr), .m_ready(m_ready),
        .s_valid(s_valid), .s_ready(s_ready), .rsp_done(rsp_done), .rsp_sel(rsp_sel),
        .busy(busy), .outstanding(outstanding), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_valid = 1'b0; m_addr = '0; s_ready = 4'hF; rsp_done = 1'b0;
        step(); step();
        rst = 1'b0; #1;
        checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rsp_sel !== 2'd0) begin errors++; $display("FAIL reset_rsp_sel got %0d want 0", rsp_sel); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", protocol_err); end
        checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0) begin errors++; $display("FAIL reset_idle_bus got s_valid=%b m_ready=%b want 0000/0", s_valid, m_ready); end
    endtask

    task automatic test_decode();
        m_valid = 1'b1; m_addr = 32'h0001_0040; s_ready = 4'hF; #1;
        checks++; if (s_valid !== 4'b0010 || m_ready !== 1'b1) begin errors++; $display("FAIL decode_s1 got s_valid=%b m_ready=%b want 0010/1", s_valid, m_ready); end
        step(); m_valid = 1'b0; #1;
        checks++; if (outstanding !== 2'd1 || rsp_sel !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL decode_track got out=%0d sel=%0d busy=%b want 1/1/1", outstanding, rsp_sel, busy); end
        rsp_done = 1'b1; step(); rsp_done = 1'b0;
        checks++; if (outstanding !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL decode_drain got out=%0d busy=%b want 0/0", outstanding, busy); end
        s_ready = 4'h0; m_valid = 1'b1; m_addr = 32'h207F_FFFC; #1;
        checks++; if (s_valid !== 4'b0100 || m_ready !== 1'b0) begin errors++; $display("FAIL decode_s2 got s_valid=%b m_ready=%b want 0100/0", s_valid, m_ready); end
        m_addr = 32'h1000_0000; #1;
        checks++; if (s_valid !== 4'b1000) begin errors++; $display("FAIL decode_default got s_valid=%b want 1000", s_valid); end
        m_valid = 1'b0; #1;
        checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0) begin errors++; $display("FAIL decode_novalid got s_valid=%b m_ready=%b want 0000/0", s_valid, m_ready); end
        s_ready = 4'hF;
    endtask

    task automatic test_ordering();
        m_valid = 1'b1; m_addr = 32'h0000_0000; step();
        checks++; if (outstanding !== 2'd1 || rsp_sel !== 2'd0) begin errors++; $display("FAIL order_first got out=%0d sel=%0d want 1/0", outstanding, rsp_sel); end
        m_addr = 32'h0001_0000; #1;
        checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0) begin errors++; $display("FAIL order_stall got s_valid=%b m_ready=%b want 0000/0", s_valid, m_ready); end
        rsp_done = 1'b1; step(); rsp_done = 1'b0; #1;
        checks++; if (outstanding !== 2'd0 || s_valid !== 4'b0010 || m_ready !== 1'b1) begin errors++; $display("FAIL order_release got out=%0d s_valid=%b m_ready=%b want 0/0010/1", outstanding, s_valid, m_ready); end
        step(); m_valid = 1'b0;
        checks++; if (outstanding !== 2'd1 || rsp_sel !== 2'd1) begin errors++; $display("FAIL order_switch got out=%0d sel=%0d want 1/1", outstanding, rsp_sel); end
        rsp_done = 1'b1; step(); rsp_done = 1'b0;
    endtask

    task automatic test_depth();
        m_valid = 1'b1; m_addr = 32'h0000_0000; step(); step();
        m_addr = 32'h0000_0100; #1;
        checks++; if (outstanding !== 2'd2 || rsp_sel !== 2'd0) begin errors++; $display("FAIL depth_fill got out=%0d sel=%0d want 2/0", outstanding, rsp_sel); end
        checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0) begin errors++; $display("FAIL depth_stall got s_valid=%b m_ready=%b want 0000/0", s_valid, m_ready); end
        rsp_done = 1'b1; #1;
        checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0) begin errors++; $display("FAIL depth_stall_rsp got s_valid=%b m_ready=%b want 0000/0", s_valid, m_ready); end
        step(); rsp_done = 1'b0; #1;
        checks++; if (outstanding !== 2'd1 || s_valid !== 4'b0001 || m_ready !== 1'b1) begin errors++; $display("FAIL depth_reopen got out=%0d s_valid=%b m_ready=%b want 1/0001/1", outstanding, s_valid, m_ready); end
        step(); m_valid = 1'b0;
        checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL depth_refill got out=%0d want 2", outstanding); end
        rsp_done = 1'b1; step(); step(); rsp_done = 1'b0;
        checks++; if (outstanding !== 2'd0 || busy !== 1'b0 || protocol_err !== 1'b0) begin errors++; $display("FAIL depth_drain got out=%0d busy=%b err=%b want 0/0/0", outstanding, busy, protocol_err); end
    endtask

    task automatic test_simultaneous();
        m_valid = 1'b1; m_addr = 32'h2000_0000; step();
        checks++; if (outstanding !== 2'd1 || rsp_sel !== 2'd2) begin errors++; $display("FAIL simul_setup got out=%0d sel=%0d want 1/2", outstanding, rsp_sel); end
        rsp_done = 1'b1; step(); m_valid = 1'b0;
        checks++; if (outstanding !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL simul_hold got out=%0d busy=%b want 1/1", outstanding, busy); end
        step(); rsp_done = 1'b0;
        checks++; if (outstanding !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL simul_drain got out=%0d busy=%b want 0/0", outstanding, busy); end
    endtask

    task automatic test_backpressure();
        m_valid = 1'b1; m_addr = 32'h0000_0000; s_ready = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (s_valid !== 4'b0001 || m_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got s_valid=%b m_ready=%b want 0001/0", i, s_valid, m_ready); end
            step();
            checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL bp_count%0d got out=%0d want 0", i, outstanding); end
        end
        s_ready = 4'hF; #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL bp_release got m_ready=%b want 1", m_ready); end
        step(); m_valid = 1'b0; step();
        checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL bp_once got out=%0d want 1", outstanding); end
        rsp_done = 1'b1; step(); rsp_done = 1'b0;
    endtask

    task automatic test_error_reset();
        rsp_done = 1'b1; step(); rsp_done = 1'b0;
        checks++; if (protocol_err !== 1'b1 || outstanding !== 2'd0) begin errors++; $display("FAIL err_set got err=%b out=%0d want 1/0", protocol_err, outstanding); end
        step();
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL err_sticky got err=%b want 1", protocol_err); end
        m_valid = 1'b1; m_addr = 32'h0000_0000; step(); step(); m_valid = 1'b0;
        checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL err_fill got out=%0d want 2", outstanding); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (outstanding !== 2'd0 || busy !== 1'b0 || rsp_sel !== 2'd0 || protocol_err !== 1'b0) begin errors++; $display("FAIL rst_mid got out=%0d busy=%b sel=%0d err=%b want 0/0/0/0", outstanding, busy, rsp_sel, protocol_err); end
        m_valid = 1'b1; m_addr = 32'h0001_0000; #1;
        checks++; if (s_valid !== 4'b0010 || m_ready !== 1'b1) begin errors++; $display("FAIL rst_first_req got s_valid=%b m_ready=%b want 0010/1", s_valid, m_ready); end
        step(); m_valid = 1'b0;
        checks++; if (outstanding !== 2'd1 || rsp_sel !== 2'd1) begin errors++; $display("FAIL rst_accept got out=%0d sel=%0d want 1/1", outstanding, rsp_sel); end
        rsp_done = 1'b1; step();
        checks++; if (protocol_err !== 1'b0 || outstanding !== 2'd0) begin errors++; $display("FAIL rst_legit_rsp got err=%b out=%0d want 0/0", protocol_err, outstanding); end
        step(); rsp_done = 1'b0;
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL rst_stale_rsp got err=%b want 1", protocol_err); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_ordering();
        test_depth();
        test_simultaneous();
        test_backpressure();
        test_error_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
